// File: rtl/counter_stream_if.sv
// counter_stream_if: sample/qualifier inputs and status outputs of counter_stream_checker (CHK_LAST_BAD_EN adds last_bad/last_exp)
interface counter_stream_if #(
    parameter int WIDTH = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     ena;
    logic [WIDTH-1:0]         data_in;
    logic                     locked;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [WIDTH-1:0]         expected;
    logic [1:0]               state;
`ifdef CHK_LAST_BAD_EN
    logic [WIDTH-1:0]         last_bad;
    logic [WIDTH-1:0]         last_exp;
`endif
    modport master (
        output ena, data_in,
        input  locked, err_pulse, err_count, expected, state
`ifdef CHK_LAST_BAD_EN
        , last_bad, last_exp
`endif
    );
    modport slave (
        input  ena, data_in,
        output locked, err_pulse, err_count, expected, state
`ifdef CHK_LAST_BAD_EN
        , last_bad, last_exp
`endif
    );
endinterface

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: locks onto an incrementing counter stream and counts sequence errors (CHK_LAST_BAD_EN captures the last bad sample)
module counter_stream_checker #(
    parameter int WIDTH = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    counter_stream_if.slave bus
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);
    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2, UNUSED = 2'd3} state_t;
    state_t                   state_q, state_n;
    logic [WIDTH-1:0]         exp_q, exp_n;
    logic [RW-1:0]            run_q, run_n, run_inc;
    logic [MW-1:0]            miss_q, miss_n, miss_inc;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_n;
    logic                     locked_q, locked_n, pulse_q, pulse_n, match;
    logic [WIDTH-1:0]         data_inc, exp_inc;
`ifdef CHK_LAST_BAD_EN
    logic [WIDTH-1:0]         bad_q, bad_n, lexp_q, lexp_n;
`endif
    assign match    = bus.data_in == exp_q;
    assign data_inc = bus.data_in + WIDTH'(1);
    assign exp_inc  = exp_q + WIDTH'(1);
    assign run_inc  = run_q + RW'(1);
    assign miss_inc = miss_q + MW'(1);
    // Next-state and next-output decode; every register holds unless a qualified sample changes it
    always_comb begin
        state_n  = state_q;
        exp_n    = exp_q;
        run_n    = run_q;
        miss_n   = miss_q;
        cnt_n    = cnt_q;
        locked_n = locked_q;
        pulse_n  = 1'b0;
`ifdef CHK_LAST_BAD_EN
        bad_n    = bad_q;
        lexp_n   = lexp_q;
`endif
        case (state_q)
            SEARCH: if (bus.ena) begin
                exp_n   = data_inc;
                run_n   = RW'(1);
                state_n = VERIFY;
            end
            VERIFY: if (bus.ena) begin
                exp_n = data_inc;
                run_n = match ? run_inc : RW'(1);
                if (match && run_inc == RW'(LOCK_COUNT)) begin
                    state_n  = LOCKED;
                    locked_n = 1'b1;
                    miss_n   = '0;
                end
            end
            LOCKED: if (bus.ena) begin
                exp_n  = exp_inc;
                miss_n = match ? '0 : miss_inc;
                if (!match) begin
                    pulse_n = 1'b1;
                    cnt_n   = &cnt_q ? cnt_q : cnt_q + ERR_CNT_WIDTH'(1);
`ifdef CHK_LAST_BAD_EN
                    bad_n   = bus.data_in;
                    lexp_n  = exp_q;
`endif
                    if (miss_inc == MW'(LOSS_COUNT)) begin
                        state_n  = SEARCH;
                        locked_n = 1'b0;
                        run_n    = '0;
                    end
                end
            end
            default: begin
                state_n  = SEARCH;
                locked_n = 1'b0;
            end
        endcase
    end
    // State and output registers; reset overrides any qualified sample on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            exp_q    <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
`ifdef CHK_LAST_BAD_EN
            bad_q    <= '0;
            lexp_q   <= '0;
`endif
        end else begin
            state_q  <= state_n;
            exp_q    <= exp_n;
            run_q    <= run_n;
            miss_q   <= miss_n;
            cnt_q    <= cnt_n;
            locked_q <= locked_n;
            pulse_q  <= pulse_n;
`ifdef CHK_LAST_BAD_EN
            bad_q    <= bad_n;
            lexp_q   <= lexp_n;
`endif
        end
    end
    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = cnt_q;
    assign bus.expected  = exp_q;
    assign bus.state     = state_q;
`ifdef CHK_LAST_BAD_EN
    assign bus.last_bad  = bad_q;
    assign bus.last_exp  = lexp_q;
`endif
endmodule

// File: tb/tb_counter_stream_checker.sv
// tb_counter_stream_checker: directed checks of lock, wrap, glitch, loss/relock, gating, reset and error saturation
module tb_counter_stream_checker;
    logic clk, rst;
    int   n_vec, n_err;
    counter_stream_if #(.WIDTH(8), .ERR_CNT_WIDTH(8)) bus ();
    counter_stream_if #(.WIDTH(8), .ERR_CNT_WIDTH(2)) sbus ();
    counter_stream_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    counter_stream_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_CNT_WIDTH(2)) sdut (
        .clk(clk), .rst(rst), .bus(sbus.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [7:0] d);
        @(negedge clk);
        bus.ena = e;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic e, input logic [7:0] d);
        @(negedge clk);
        sbus.ena = e;
        sbus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ena = 1'b0;
        sbus.ena = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.state, bus.locked, bus.err_pulse, bus.err_count, bus.expected} !== 20'h0) begin
            n_err++;
            $display("FAIL reset: state=%0d locked=%b pulse=%b cnt=%0d exp=%h, want all 0",
                     bus.state, bus.locked, bus.err_pulse, bus.err_count, bus.expected);
        end
    endtask

    task automatic test_lock();
        logic seen = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(i));
            seen |= bus.err_pulse;
            if (i == 2) begin
                n_vec++;
                if (bus.locked !== 1'b0 || bus.state !== 2'd1) begin
                    n_err++;
                    $display("FAIL lock_early: locked=%b state=%0d, want 0/1", bus.locked, bus.state);
                end
            end
            if (i == 3) begin
                n_vec++;
                if (bus.locked !== 1'b1 || bus.state !== 2'd2) begin
                    n_err++;
                    $display("FAIL lock_rise: locked=%b state=%0d, want 1/2", bus.locked, bus.state);
                end
            end
        end
        n_vec++;
        if (bus.expected !== 8'h06 || bus.err_count !== 8'd0 || seen !== 1'b0) begin
            n_err++;
            $display("FAIL lock_final: exp=%h cnt=%0d pulse_seen=%b, want 06/0/0", bus.expected, bus.err_count, seen);
        end
    endtask

    task automatic test_reseed();
        do_reset();
        step(1'b1, 8'h10);
        step(1'b1, 8'h11);
        step(1'b1, 8'h50);
        step(1'b1, 8'h51);
        step(1'b1, 8'h52);
        n_vec++;
        if (bus.locked !== 1'b0 || bus.expected !== 8'h53) begin
            n_err++;
            $display("FAIL reseed_hold: locked=%b exp=%h, want 0/53", bus.locked, bus.expected);
        end
        step(1'b1, 8'h53);
        n_vec++;
        if (bus.locked !== 1'b1 || bus.err_count !== 8'd0) begin
            n_err++;
            $display("FAIL reseed_lock: locked=%b cnt=%0d, want 1/0", bus.locked, bus.err_count);
        end
    endtask

    task automatic test_wrap();
        logic seen = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'hFC + i));
            if (i >= 4) seen |= bus.err_pulse;
        end
        n_vec++;
        if (bus.locked !== 1'b1 || seen !== 1'b0 || bus.expected !== 8'h02 || bus.err_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap: locked=%b pulse_seen=%b exp=%h cnt=%0d, want 1/0/02/0",
                     bus.locked, seen, bus.expected, bus.err_count);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h1C + i));
        n_vec++;
        if (bus.locked !== 1'b1 || bus.expected !== 8'h20) begin
            n_err++;
            $display("FAIL glitch_setup: locked=%b exp=%h, want 1/20", bus.locked, bus.expected);
        end
        step(1'b1, 8'h55);
        n_vec++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b1 || bus.expected !== 8'h21) begin
            n_err++;
            $display("FAIL glitch_hit: pulse=%b cnt=%0d locked=%b exp=%h, want 1/1/1/21",
                     bus.err_pulse, bus.err_count, bus.locked, bus.expected);
        end
`ifdef CHK_LAST_BAD_EN
        n_vec++;
        if (bus.last_bad !== 8'h55 || bus.last_exp !== 8'h20) begin
            n_err++;
            $display("FAIL glitch_capture: last_bad=%h last_exp=%h, want 55/20", bus.last_bad, bus.last_exp);
        end
`endif
        step(1'b1, 8'h21);
        n_vec++;
        if (bus.err_pulse !== 1'b0 || bus.err_count !== 8'd1 || bus.locked !== 1'b1 || bus.expected !== 8'h22) begin
            n_err++;
            $display("FAIL glitch_recover: pulse=%b cnt=%0d locked=%b exp=%h, want 0/1/1/22",
                     bus.err_pulse, bus.err_count, bus.locked, bus.expected);
        end
    endtask

    task automatic test_loss_relock();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h99);
            n_vec++;
            if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'(i + 1) || bus.locked !== (i < 2)) begin
                n_err++;
                $display("FAIL loss_miss%0d: pulse=%b cnt=%0d locked=%b, want 1/%0d/%b",
                         i, bus.err_pulse, bus.err_count, bus.locked, i + 1, i < 2);
            end
        end
        n_vec++;
        if (bus.state !== 2'd0) begin
            n_err++;
            $display("FAIL loss_state: state=%0d, want 0", bus.state);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i));
        n_vec++;
        if (bus.locked !== 1'b0 || bus.state !== 2'd1) begin
            n_err++;
            $display("FAIL relock_early: locked=%b state=%0d, want 0/1", bus.locked, bus.state);
        end
        step(1'b1, 8'h43);
        n_vec++;
        if (bus.locked !== 1'b1 || bus.err_count !== 8'd3 || bus.expected !== 8'h44) begin
            n_err++;
            $display("FAIL relock: locked=%b cnt=%0d exp=%h, want 1/3/44", bus.locked, bus.err_count, bus.expected);
        end
    endtask

    task automatic test_gating_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'($urandom_range(255)));
            n_vec++;
            if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd3 ||
                bus.expected !== 8'h44 || bus.state !== 2'd2) begin
                n_err++;
                $display("FAIL gate%0d: locked=%b pulse=%b cnt=%0d exp=%h state=%0d, want 1/0/3/44/2",
                         i, bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.state);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.data_in = 8'h44;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ena = 1'b0;
        n_vec++;
        if ({bus.state, bus.locked, bus.err_pulse, bus.err_count, bus.expected} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_mid_lock: state=%0d locked=%b pulse=%b cnt=%0d exp=%h, want all 0",
                     bus.state, bus.locked, bus.err_pulse, bus.err_count, bus.expected);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) step2(1'b1, 8'(i));
        for (int i = 0; i < 5; i++) begin
            step2(1'b1, 8'hEE);
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            n_vec++;
            if (sbus.err_pulse !== 1'b1 || sbus.err_count !== want || sbus.locked !== 1'b1) begin
                n_err++;
                $display("FAIL sat%0d: pulse=%b cnt=%0d locked=%b, want 1/%0d/1",
                         i, sbus.err_pulse, sbus.err_count, sbus.locked, want);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.ena = 1'b0;
        bus.data_in = '0;
        sbus.ena = 1'b0;
        sbus.data_in = '0;
        test_reset();
        test_lock();
        test_reseed();
        test_wrap();
        test_glitch();
        test_loss_relock();
        test_gating_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
